// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 8-bit CPU control unit: field widths, opcode
// values, controller state encoding and small decode helpers.
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int OP_W      = 4;
    localparam int REG_IDX_W = 2;
    localparam int DATA_W    = 8;

    // Ops 0x0-0x7 are passed straight through to the ALU as its opcode.
    localparam logic [OP_W-1:0] OP_LDI = 4'h8;
    localparam logic [OP_W-1:0] OP_JMP = 4'h9;
    localparam logic [OP_W-1:0] OP_JZ  = 4'hA;
    localparam logic [OP_W-1:0] OP_JC  = 4'hB;
    localparam logic [OP_W-1:0] OP_MOV = 4'hC;
    localparam logic [OP_W-1:0] OP_SHA = 4'hD;
    localparam logic [OP_W-1:0] OP_NOP = 4'hE;
    localparam logic [OP_W-1:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_FETCH_IMM,
        ST_EXEC,
        ST_WB,
        ST_HALT
    } ctrl_state_t;

    function automatic logic is_alu_op(input logic [OP_W-1:0] op);
        return !op[OP_W-1];
    endfunction

    function automatic logic has_imm(input logic [OP_W-1:0] op);
        return (op == OP_LDI) || (op == OP_JMP) || (op == OP_JZ) ||
               (op == OP_JC)  || (op == OP_SHA);
    endfunction

endpackage

// File: rtl/ctrl_regfile.sv
// -----------------------------------------------------------------------------
// ctrl_regfile
// 4 x 8-bit register file: two combinational read ports, one synchronous
// write port, asynchronous active-low clear of every entry.
//   clk, rst_n          clock / async active-low clear
//   we, waddr, wdata    write port (rising edge)
//   raddr_a / rdata_a   read port A (combinational)
//   raddr_b / rdata_b   read port B (combinational)
// -----------------------------------------------------------------------------
module ctrl_regfile
    import cpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] waddr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic [REG_IDX_W-1:0] raddr_a,
    output logic [DATA_W-1:0]    rdata_a,
    input  logic [REG_IDX_W-1:0] raddr_b,
    output logic [DATA_W-1:0]    rdata_b
);

    logic [DATA_W-1:0] regs [1 << REG_IDX_W];

    // NOTE: this array is reset on purpose -- software relies on all registers
    // reading 0 after reset, and with four entries it stays a flop array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < (1 << REG_IDX_W); i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/cpu_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_ctrl
// Multi-cycle control unit: fetches instructions (plus an optional immediate
// byte), sequences the external ALU, writes results back and evaluates
// conditional jumps on the registered zero/carry flags.
//   clk, rst_n                       clock / async active-low reset
//   mem_addr, mem_rdata              program memory (address = PC)
//   enable_alu, alu_opcode,
//   alu_a, alu_b, shamp              ALU controls and operands
//   alu_out, flag_zero, flag_carry   ALU result, sampled in WB
//   halted                           high while stopped in HALT
// -----------------------------------------------------------------------------
module cpu_ctrl
    import cpu_pkg::*;
#(
    parameter logic [DATA_W-1:0] PC_RESET = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              flag_zero,
    input  logic              flag_carry,
    output logic              enable_alu,
    output logic [OP_W-1:0]   alu_opcode,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [DATA_W-1:0] shamp,
    output logic              halted
);

    ctrl_state_t       state_q, state_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [DATA_W-1:0] shamp_q, shamp_d;
    logic              z_q, z_d;
    logic              c_q, c_d;

    logic              rf_we;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rd_data, rs_data;

    logic [OP_W-1:0]      op;
    logic [REG_IDX_W-1:0] rd, rs;

    assign op = ir_q[DATA_W-1 -: OP_W];
    assign rd = ir_q[2*REG_IDX_W-1 -: REG_IDX_W];
    assign rs = ir_q[REG_IDX_W-1:0];

    ctrl_regfile u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (rf_we),
        .waddr   (rd),
        .wdata   (rf_wdata),
        .raddr_a (rd),
        .rdata_a (rd_data),
        .raddr_b (rs),
        .rdata_b (rs_data)
    );

    // NOTE: every signal driven here gets its default first, so no path
    // through the case statement can leave a latch behind.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        imm_d    = imm_q;
        shamp_d  = shamp_q;
        z_d      = z_q;
        c_d      = c_q;
        rf_we    = 1'b0;
        rf_wdata = imm_q;

        case (state_q)
            ST_FETCH: begin
                ir_d    = mem_rdata;
                pc_d    = pc_q + DATA_W'(1);
                // Decode the byte being fetched, not the stale IR.
                state_d = has_imm(mem_rdata[DATA_W-1 -: OP_W]) ? ST_FETCH_IMM : ST_EXEC;
            end
            ST_FETCH_IMM: begin
                imm_d   = mem_rdata;
                pc_d    = pc_q + DATA_W'(1);
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (is_alu_op(op)) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_FETCH;
                    case (op)
                        OP_LDI: begin
                            rf_we    = 1'b1;
                            rf_wdata = imm_q;
                        end
                        OP_MOV: begin
                            rf_we    = 1'b1;
                            rf_wdata = rs_data;
                        end
                        OP_SHA: shamp_d = imm_q;
                        OP_JMP: pc_d = imm_q;
                        OP_JZ:  if (z_q) pc_d = imm_q;
                        OP_JC:  if (c_q) pc_d = imm_q;
                        OP_HLT: state_d = ST_HALT;
                        default: ;  // NOP
                    endcase
                end
            end
            ST_WB: begin
                rf_we    = 1'b1;
                rf_wdata = alu_out;
                z_d      = flag_zero;
                c_d      = flag_carry;
                state_d  = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            pc_q    <= PC_RESET;
            ir_q    <= '0;
            imm_q   <= '0;
            shamp_q <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            imm_q   <= imm_d;
            shamp_q <= shamp_d;
            z_q     <= z_d;
            c_q     <= c_d;
        end
    end

    // Outputs depend only on registered state (and register-file contents),
    // so they are stable across the whole EXEC cycle.
    assign enable_alu = (state_q == ST_EXEC) && is_alu_op(op);
    assign alu_opcode = (((state_q == ST_EXEC) || (state_q == ST_WB)) && is_alu_op(op)) ? op : '0;
    assign alu_a      = rd_data;
    assign alu_b      = rs_data;
    assign shamp      = shamp_q;
    assign mem_addr   = pc_q;
    assign halted     = (state_q == ST_HALT);

endmodule

// File: tb/tb_cpu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpu_ctrl
// Drives cpu_ctrl with small directed programs. An instruction-level model
// turns each instruction into its expected per-cycle output trace, which a
// compare process checks on every falling edge; literal checks pin key points.
// -----------------------------------------------------------------------------
module tb_cpu_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] mem_rdata;
    logic [7:0] mem_addr;
    logic [7:0] alu_out;
    logic       flag_zero;
    logic       flag_carry;
    logic       enable_alu;
    logic [3:0] alu_opcode;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] shamp;
    logic       halted;

    logic [7:0] mem [256];
    logic       zero_mode;   // bench ALU forces result 0 / zero flag 1

    int checks = 0;
    int errors = 0;

    cpu_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_rdata  (mem_rdata),
        .mem_addr   (mem_addr),
        .alu_out    (alu_out),
        .flag_zero  (flag_zero),
        .flag_carry (flag_carry),
        .enable_alu (enable_alu),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .shamp      (shamp),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference ALU: returns {carry, zero, result}.
    function automatic logic [9:0] alu_ref(input logic [3:0] op, input logic [7:0] a,
                                           input logic [7:0] b, input logic [7:0] sh,
                                           input logic fz);
        logic [8:0] w;
        case (op)
            4'd0:    w = {1'b0, a} + {1'b0, b};
            4'd1:    w = {1'b0, a} - {1'b0, b};
            4'd2:    w = {1'b0, a & b};
            4'd3:    w = {1'b0, a | b};
            4'd4:    w = {1'b0, a ^ b};
            4'd5:    w = {1'b0, a << sh[2:0]};
            4'd6:    w = {1'b0, a >> sh[2:0]};
            default: w = {1'b0, ~a};
        endcase
        if (fz) return 10'b01_0000_0000;
        return {w[8], (w[7:0] == 8'h00), w[7:0]};
    endfunction

    // Bench ALU: result valid the cycle after an enabled edge.
    always @(posedge clk) begin
        if (enable_alu) begin
            {flag_carry, flag_zero, alu_out} <= alu_ref(alu_opcode, alu_a, alu_b, shamp, zero_mode);
        end
    end

    // ---------------- instruction-level model ----------------
    typedef struct {
        logic [7:0] addr;
        logic       en;
        logic [3:0] opc;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] sh;
        logic       halt;
        logic       chk_ab;
    } rec_t;

    rec_t       exp_q[$];
    logic [7:0] m_pc;
    logic [7:0] m_r [4];
    logic       m_z, m_c, m_halt;
    logic [7:0] m_sh;

    task automatic model_reset();
        exp_q.delete();
        m_pc   = 8'h00;
        m_z    = 1'b0;
        m_c    = 1'b0;
        m_halt = 1'b0;
        m_sh   = 8'h00;
        for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    endtask

    task automatic push_rec(input logic [7:0] addr, input logic en, input logic [3:0] opc,
                            input logic [7:0] a, input logic [7:0] b, input logic chk_ab,
                            input logic halt);
        rec_t r;
        r.addr = addr; r.en = en; r.opc = opc; r.a = a; r.b = b;
        r.sh = m_sh; r.halt = halt; r.chk_ab = chk_ab;
        exp_q.push_back(r);
    endtask

    // Executes one instruction on the model and queues its expected cycles.
    task automatic gen();
        logic [7:0] ins, imm, p1, p2;
        logic [3:0] op;
        logic [1:0] rd, rs;
        logic [9:0] res;
        logic       hasi;
        if (m_halt) begin
            push_rec(m_pc, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b1);
            return;
        end
        ins  = mem[m_pc];
        op   = ins[7:4];
        rd   = ins[3:2];
        rs   = ins[1:0];
        p1   = m_pc + 8'd1;
        p2   = m_pc + 8'd2;
        imm  = mem[p1];
        hasi = (op == 4'h8) || (op == 4'h9) || (op == 4'hA) || (op == 4'hB) || (op == 4'hD);
        push_rec(m_pc, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0);
        if (hasi) push_rec(p1, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0);
        if (op < 4'h8) begin
            push_rec(p1, 1'b1, op, m_r[rd], m_r[rs], 1'b1, 1'b0);
            push_rec(p1, 1'b0, op, 8'h00, 8'h00, 1'b0, 1'b0);
            res     = alu_ref(op, m_r[rd], m_r[rs], m_sh, zero_mode);
            m_r[rd] = res[7:0];
            m_z     = res[8];
            m_c     = res[9];
            m_pc    = p1;
        end else begin
            push_rec(hasi ? p2 : p1, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0);
            m_pc = hasi ? p2 : p1;
            case (op)
                4'h8: m_r[rd] = imm;
                4'h9: m_pc = imm;
                4'hA: if (m_z) m_pc = imm;
                4'hB: if (m_c) m_pc = imm;
                4'hC: m_r[rd] = m_r[rs];
                4'hD: m_sh = imm;
                4'hF: m_halt = 1'b1;
                default: ;
            endcase
        end
    endtask

    always @(negedge clk) begin : compare
        rec_t r;
        if (!rst_n) begin
            model_reset();
        end else begin
            if (exp_q.size() == 0) gen();
            r = exp_q.pop_front();
            check("mem_addr", {24'd0, mem_addr}, {24'd0, r.addr});
            check("enable_alu", {31'd0, enable_alu}, {31'd0, r.en});
            check("alu_opcode", {28'd0, alu_opcode}, {28'd0, r.opc});
            check("shamp", {24'd0, shamp}, {24'd0, r.sh});
            check("halted", {31'd0, halted}, {31'd0, r.halt});
            if (r.chk_ab) begin
                check("alu_a", {24'd0, alu_a}, {24'd0, r.a});
                check("alu_b", {24'd0, alu_b}, {24'd0, r.b});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 256; i++) mem[i] = v;
    endtask

    task automatic hold_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Waits n rising edges, then samples 1 time unit later.
    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_alu_prog();
        fill(8'hE0);
        mem[0] = 8'h80; mem[1] = 8'hF0;   // LDI R0,240
        mem[2] = 8'h84; mem[3] = 8'h1E;   // LDI R1,30
        mem[4] = 8'hD0; mem[5] = 8'hF0;   // SHA 240
        mem[6] = 8'h21;                   // op2 R0,R1
        mem[7] = 8'hA0; mem[8] = 8'h40;   // JZ 0x40
        mem[9] = 8'hF0;                   // HLT
        mem[8'h40] = 8'hF0;               // HLT
    endtask

    initial begin
        rst_n     = 1'b0;
        zero_mode = 1'b0;
        alu_out   = 8'h00;
        flag_zero = 1'b0;
        flag_carry = 1'b0;
        fill(8'hE0);
        #1;
        check("rst mem_addr", {24'd0, mem_addr}, 32'h00);
        check("rst enable_alu", {31'd0, enable_alu}, 32'h0);
        check("rst alu_opcode", {28'd0, alu_opcode}, 32'h0);
        check("rst halted", {31'd0, halted}, 32'h0);
        check("rst shamp", {24'd0, shamp}, 32'h00);

        // All-NOP program: one PC step every 2 cycles, wrapping FF->00.
        release_reset();
        run(6);
        check("nop pc after 6", {24'd0, mem_addr}, 32'h03);
        run(504);
        check("nop pc after 510", {24'd0, mem_addr}, 32'hFF);
        run(2);
        check("nop pc wrap", {24'd0, mem_addr}, 32'h00);

        // ALU op with SHA, zero result -> JZ taken.
        hold_reset();
        load_alu_prog();
        zero_mode = 1'b1;
        release_reset();
        run(10);
        check("exec enable_alu", {31'd0, enable_alu}, 32'h1);
        check("exec alu_opcode", {28'd0, alu_opcode}, 32'h2);
        check("exec alu_a", {24'd0, alu_a}, 32'd240);
        check("exec alu_b", {24'd0, alu_b}, 32'd30);
        check("exec shamp", {24'd0, shamp}, 32'd240);
        run(1);
        check("wb enable_alu", {31'd0, enable_alu}, 32'h0);
        run(4);
        check("jz taken pc", {24'd0, mem_addr}, 32'h40);
        run(22);
        check("halt taken", {31'd0, halted}, 32'h1);
        check("halt pc taken", {24'd0, mem_addr}, 32'h41);

        // Same program, nonzero result -> JZ falls through.
        hold_reset();
        load_alu_prog();
        zero_mode = 1'b0;
        release_reset();
        run(15);
        check("jz not taken pc", {24'd0, mem_addr}, 32'h09);
        run(22);
        check("halt not taken", {31'd0, halted}, 32'h1);
        check("halt pc not taken", {24'd0, mem_addr}, 32'h0A);

        // Carry from add, MOV keeps flags, JC taken, JMP to itself loops.
        hold_reset();
        fill(8'hE0);
        mem[0] = 8'h80; mem[1] = 8'hFF;   // LDI R0,255
        mem[2] = 8'h84; mem[3] = 8'h01;   // LDI R1,1
        mem[4] = 8'h01;                   // add R0,R1 -> 0, carry
        mem[5] = 8'hC8;                   // MOV R2,R0
        mem[6] = 8'hB0; mem[7] = 8'h0A;   // JC 0x0A
        mem[8] = 8'hF0; mem[9] = 8'hF0;
        mem[10] = 8'h90; mem[11] = 8'h0A; // JMP 0x0A
        release_reset();
        run(14);
        check("jc taken pc", {24'd0, mem_addr}, 32'h0A);
        run(30);
        check("self loop pc", {24'd0, mem_addr}, 32'h0A);
        check("self loop running", {31'd0, halted}, 32'h0);

        // Immediate fetch across FF->00.
        hold_reset();
        fill(8'hE0);
        mem[0] = 8'h90; mem[1] = 8'hFF;   // JMP 0xFF
        mem[8'hFF] = 8'h80;               // LDI R0, imm = mem[0x00]
        release_reset();
        run(12);
        check("imm wrap halted", {31'd0, halted}, 32'h1);
        check("imm wrap pc", {24'd0, mem_addr}, 32'h02);

        // Reset in the middle of an ALU EXEC.
        hold_reset();
        fill(8'hE0);
        mem[0] = 8'h80; mem[1] = 8'h05;   // LDI R0,5
        mem[2] = 8'h84; mem[3] = 8'h03;   // LDI R1,3
        mem[4] = 8'h01;                   // add R0,R1
        release_reset();
        run(7);
        check("pre-rst enable_alu", {31'd0, enable_alu}, 32'h1);
        check("pre-rst alu_a", {24'd0, alu_a}, 32'h05);
        #1 rst_n = 1'b0;
        #1;
        check("mid-rst enable_alu", {31'd0, enable_alu}, 32'h0);
        check("mid-rst alu_opcode", {28'd0, alu_opcode}, 32'h0);
        check("mid-rst mem_addr", {24'd0, mem_addr}, 32'h00);
        fill(8'hE0);
        mem[0] = 8'h01;                   // add R0,R1 straight after reset
        release_reset();
        run(1);
        check("restart enable_alu", {31'd0, enable_alu}, 32'h1);
        check("restart alu_a", {24'd0, alu_a}, 32'h00);
        check("restart alu_b", {24'd0, alu_b}, 32'h00);
        check("restart mem_addr", {24'd0, mem_addr}, 32'h01);
        run(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
